// File: rtl/ps2_pkg.sv
// PS/2 keyboard controller shared types and constants.
// Scancode prefixes, decoder states and the key-event record.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } kbd_state_e;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_FA = 8'hFA;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_EE = 8'hEE;
    localparam logic [7:0] CODE_FE = 8'hFE;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERR1 = 8'hFF;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } kbd_event_t;

    function automatic kbd_event_t mk_event(
        input logic [7:0] code,
        input logic       ext,
        input logic       brk
    );
        kbd_event_t ev;
        ev.code = code;
        ev.ext  = ext;
        ev.brk  = brk;
        return ev;
    endfunction

    function automatic logic is_ack_code(input logic [7:0] c);
        return (c == CODE_FA) || (c == CODE_AA) ||
               (c == CODE_EE) || (c == CODE_FE);
    endfunction

    function automatic logic is_err_code(input logic [7:0] c);
        return (c == CODE_ERR0) || (c == CODE_ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead key-event FIFO with exact occupancy count.
// Head data reads as zero while the FIFO is empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       push,
    input  kbd_event_t wdata,
    input  logic       pop,
    output kbd_event_t rdata,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    kbd_event_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk32) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents only matter behind the pointers.
    always_ff @(posedge clk32) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scancode set 2 decoder feeding a key-event FIFO.
// Tracks E0/F0/E1 prefixes, prefix timeout and sticky flags.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int PREFIX_TIMEOUT = 32000
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       kbd_int,
    input  logic [7:0] kbd_code,
    input  logic       rd,
    input  logic       clr_flags,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       kbd_err
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    kbd_state_e    state;
    kbd_state_e    state_nxt;
    logic [2:0]    skip;
    logic [2:0]    skip_nxt;
    logic [TW-1:0] tmo;
    logic          tmo_hit;
    logic          push;
    kbd_event_t    push_ev;
    logic          err_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    kbd_event_t    head;

    // Abandon a partial sequence in the cycle the counter runs out.
    assign tmo_hit = !kbd_int && (state != ST_IDLE) &&
                     (tmo <= TW'(1));

    // Full FIFO can still accept a push when the head leaves.
    assign fifo_drop = push && fifo_full && !rd;

    // Next-state and event decode for each received byte.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        push      = 1'b0;
        push_ev   = '0;
        err_hit   = 1'b0;
        if (kbd_int) begin
            if (is_err_code(kbd_code)) begin
                err_hit   = 1'b1;
                state_nxt = ST_IDLE;
                skip_nxt  = 3'd0;
            end else if (state == ST_PAUSE) begin
                skip_nxt = skip - 3'd1;
                if (skip <= 3'd1) begin
                    push      = 1'b1;
                    push_ev   = mk_event(CODE_E1, 1'b0, 1'b0);
                    state_nxt = ST_IDLE;
                    skip_nxt  = 3'd0;
                end
            end else if (kbd_code == CODE_E1) begin
                state_nxt = ST_PAUSE;
                skip_nxt  = PAUSE_SKIP;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        unique case (1'b1)
                            kbd_code == CODE_E0: state_nxt = ST_EXT;
                            kbd_code == CODE_F0: state_nxt = ST_BRK;
                            is_ack_code(kbd_code): state_nxt = ST_IDLE;
                            default: begin
                                push    = 1'b1;
                                push_ev = mk_event(kbd_code, 1'b0, 1'b0);
                            end
                        endcase
                    end
                    ST_EXT: begin
                        unique case (1'b1)
                            kbd_code == CODE_F0: state_nxt = ST_EXT_BRK;
                            kbd_code == CODE_E0: state_nxt = ST_EXT;
                            default: begin
                                push      = 1'b1;
                                push_ev   = mk_event(kbd_code, 1'b1, 1'b0);
                                state_nxt = ST_IDLE;
                            end
                        endcase
                    end
                    ST_BRK: begin
                        unique case (1'b1)
                            kbd_code == CODE_E0: state_nxt = ST_EXT_BRK;
                            kbd_code == CODE_F0: state_nxt = ST_BRK;
                            default: begin
                                push      = 1'b1;
                                push_ev   = mk_event(kbd_code, 1'b0, 1'b1);
                                state_nxt = ST_IDLE;
                            end
                        endcase
                    end
                    ST_EXT_BRK: begin
                        unique case (1'b1)
                            kbd_code == CODE_E0: state_nxt = ST_EXT_BRK;
                            kbd_code == CODE_F0: state_nxt = ST_EXT_BRK;
                            default: begin
                                push      = 1'b1;
                                push_ev   = mk_event(kbd_code, 1'b1, 1'b1);
                                state_nxt = ST_IDLE;
                            end
                        endcase
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end else if (tmo_hit) begin
            state_nxt = ST_IDLE;
            skip_nxt  = 3'd0;
        end
    end

    // Decoder state, pause skip counter and prefix timeout.
    always_ff @(posedge clk32) begin
        if (reset) begin
            state <= ST_IDLE;
            skip  <= 3'd0;
            tmo   <= '0;
        end else begin
            state <= state_nxt;
            skip  <= skip_nxt;
            if (kbd_int) begin
                tmo <= TW'(PREFIX_TIMEOUT);
            end else if (tmo != '0) begin
                tmo <= tmo - TW'(1);
            end
        end
    end

    // Sticky flags; a new set wins over a clear in the same cycle.
    always_ff @(posedge clk32) begin
        if (reset) begin
            overflow <= 1'b0;
            kbd_err  <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (err_hit) begin
                kbd_err <= 1'b1;
            end else if (clr_flags) begin
                kbd_err <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk32 (clk32),
        .reset (reset),
        .push  (push),
        .wdata (push_ev),
        .pop   (rd),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign event_valid = !fifo_empty;
    assign event_code  = head.code;
    assign event_ext   = head.ext;
    assign event_break = head.brk;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl.
// Stimulus queues expected events; a monitor drains and compares.
module tb_ps2_kbd_ctrl;

    logic       clk32 = 1'b0;
    logic       reset;
    logic       kbd_int;
    logic [7:0] kbd_code;
    logic       rd;
    logic       clr_flags;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       kbd_err;

    logic stim_rd  = 1'b0;
    logic mon_rd   = 1'b0;
    logic drain_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q [$];

    assign rd = stim_rd | mon_rd;

    always #5 clk32 = ~clk32;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH     (8),
        .PREFIX_TIMEOUT (32000)
    ) u_dut (
        .clk32       (clk32),
        .reset       (reset),
        .kbd_int     (kbd_int),
        .kbd_code    (kbd_code),
        .rd          (rd),
        .clr_flags   (clr_flags),
        .event_valid (event_valid),
        .event_code  (event_code),
        .event_ext   (event_ext),
        .event_break (event_break),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .kbd_err     (kbd_err)
    );

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        kbd_int  = 1'b1;
        kbd_code = b;
        @(negedge clk32);
        kbd_int  = 1'b0;
        kbd_code = 8'h00;
    endtask

    task automatic expect_ev(
        input logic [7:0] c,
        input logic       e,
        input logic       b
    );
        exp_q.push_back({c, e, b});
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk32);
        clr_flags = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        drain_en = 1'b1;
        repeat (2) @(negedge clk32);
        while ((exp_q.size() != 0 || event_valid) && k < 200) begin
            @(negedge clk32);
            k++;
        end
        check(name, exp_q.size() + 32'(event_valid), 0);
    endtask

    // Monitor: pop the head whenever it is presented and compare.
    always @(negedge clk32) begin
        logic [9:0] exp;
        mon_rd = 1'b0;
        if (drain_en && event_valid && !reset) begin
            mon_rd = 1'b1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got %0h expected none",
                         {event_code, event_ext, event_break});
            end else begin
                exp = exp_q.pop_front();
                check("event", {22'd0, event_code, event_ext, event_break},
                      {22'd0, exp});
            end
        end
    end

    initial begin
        #5_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [9:0] exp;
        reset     = 1'b1;
        kbd_int   = 1'b0;
        kbd_code  = 8'h00;
        clr_flags = 1'b0;
        repeat (3) @(negedge clk32);
        check("rst_valid", 32'(event_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_head", {event_code, event_ext, event_break}, 0);
        check("rst_flags", {overflow, kbd_err}, 0);
        reset = 1'b0;
        @(negedge clk32);

        // Make then break of the same key.
        send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'hF0);
        send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b1);
        check("make_brk_count", 32'(fifo_count), 2);
        wait_drain("make_brk_drain");

        // Extended break, then a plain key decoded from IDLE.
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        expect_ev(8'h75, 1'b1, 1'b1);
        send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0);
        wait_drain("ext_brk_drain");

        // Pause sequence: one event on the eighth byte.
        drain_en = 1'b0;
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        check("pause_7th", 32'(event_valid), 0);
        send(8'h77);
        check("pause_8th", 32'(event_valid), 1);
        expect_ev(8'hE1, 1'b0, 1'b0);
        wait_drain("pause_drain");

        // Acknowledge codes ignored, double E0 stays extended.
        send(8'hFA);
        send(8'hAA);
        send(8'hEE);
        send(8'hFE);
        send(8'h5A);
        expect_ev(8'h5A, 1'b0, 1'b0);
        send(8'hE0);
        send(8'hE0);
        send(8'h12);
        expect_ev(8'h12, 1'b1, 1'b0);
        wait_drain("ack_ext_drain");

        // Prefix survives 31999 idle cycles but not 32000.
        send(8'hE0);
        repeat (31999) @(negedge clk32);
        send(8'h6B);
        expect_ev(8'h6B, 1'b1, 1'b0);
        send(8'hE0);
        repeat (32000) @(negedge clk32);
        send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0);
        wait_drain("timeout_drain");

        // Error codes: flag set, sequence discarded, clear, set wins.
        send(8'hFF);
        check("err_set", 32'(kbd_err), 1);
        check("err_no_event", 32'(event_valid), 0);
        send(8'hE0);
        send(8'h00);
        send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0);
        pulse_clr();
        check("err_clr", 32'(kbd_err), 0);
        clr_flags = 1'b1;
        send(8'hFF);
        clr_flags = 1'b0;
        check("err_set_wins", 32'(kbd_err), 1);
        pulse_clr();
        wait_drain("err_drain");

        // Pop on empty is ignored.
        stim_rd = 1'b1;
        @(negedge clk32);
        stim_rd = 1'b0;
        check("empty_pop", {27'd0, fifo_count}, 0);

        // Push and pop together on an empty FIFO.
        drain_en = 1'b0;
        @(negedge clk32);
        stim_rd = 1'b1;
        send(8'h2C);
        stim_rd = 1'b0;
        expect_ev(8'h2C, 1'b0, 1'b0);
        check("empty_pushpop", 32'(fifo_count), 1);
        wait_drain("empty_pp_drain");

        // Overflow: nine makes into a depth-8 FIFO.
        drain_en = 1'b0;
        @(negedge clk32);
        for (int i = 0; i < 9; i++) begin
            send(8'h15 + 8'(i));
            if (i < 8) expect_ev(8'h15 + 8'(i), 1'b0, 1'b0);
        end
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_flag", 32'(overflow), 1);
        pulse_clr();
        check("ovf_clr", 32'(overflow), 0);
        exp = exp_q.pop_front();
        check("pp_head", {event_code, event_ext, event_break}, {22'd0, exp});
        stim_rd = 1'b1;
        send(8'h40);
        stim_rd = 1'b0;
        expect_ev(8'h40, 1'b0, 1'b0);
        check("pp_count", 32'(fifo_count), 8);
        check("pp_no_ovf", 32'(overflow), 0);
        clr_flags = 1'b1;
        send(8'h41);
        clr_flags = 1'b0;
        check("ovf_set_wins", 32'(overflow), 1);
        check("ovf_kept", 32'(fifo_count), 8);
        pulse_clr();
        wait_drain("ovf_drain");

        // Reset mid-sequence flushes everything and wins.
        drain_en = 1'b0;
        @(negedge clk32);
        send(8'h33);
        send(8'hFF);
        send(8'hF0);
        reset     = 1'b1;
        kbd_int   = 1'b1;
        kbd_code  = 8'h1C;
        stim_rd   = 1'b1;
        clr_flags = 1'b1;
        @(negedge clk32);
        kbd_int   = 1'b0;
        stim_rd   = 1'b0;
        clr_flags = 1'b0;
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_valid", 32'(event_valid), 0);
        check("mid_rst_head", {event_code, event_ext, event_break}, 0);
        check("mid_rst_flags", {overflow, kbd_err}, 0);
        reset = 1'b0;
        @(negedge clk32);
        send(8'h1C);
        expect_ev(8'h1C, 1'b0, 1'b0);
        wait_drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
